// File: rtl/odom_integrator.sv
// rtl/odom_integrator.sv - dead-reckoning pose integrator with one shared sign-magnitude multiplier
module odom_integrator #(
   parameter int N_WIDTH     = 17,
   parameter int Q_WIDTH     = 8,
   parameter int TICK_CYCLES = 500000,
   parameter int DT_K        = 3,
   parameter int DTDEG_K     = 147,
   parameter logic [N_WIDTH-1:0] X_INIT     = '0,
   parameter logic [N_WIDTH-1:0] Y_INIT     = '0,
   parameter logic [N_WIDTH-1:0] THETA_INIT = N_WIDTH'(90 << Q_WIDTH)
) (
   input  logic               ODOM_INTEGRATOR_CLOCK_50,
   input  logic               ODOM_INTEGRATOR_RESET_InLow,
   input  logic               ODOM_INTEGRATOR_SETBEGIN_InLow,
   input  logic               ODOM_INTEGRATOR_ENABLE_InHigh,
   input  logic [N_WIDTH-1:0] ODOM_INTEGRATOR_VX_InBus,
   input  logic [N_WIDTH-1:0] ODOM_INTEGRATOR_VY_InBus,
   input  logic [N_WIDTH-1:0] ODOM_INTEGRATOR_WZ_InBus,
   output logic [N_WIDTH-1:0] ODOM_INTEGRATOR_POSX_OutBus,
   output logic [N_WIDTH-1:0] ODOM_INTEGRATOR_POSY_OutBus,
   output logic [N_WIDTH-1:0] ODOM_INTEGRATOR_THETA_OutBus,
   output logic               ODOM_INTEGRATOR_UPDATE_OutHigh,
   output logic [1:0]         ODOM_INTEGRATOR_OVF_OutBus
);

   localparam int MW = N_WIDTH - 1;          // magnitude width
   localparam int PW = MW + Q_WIDTH;         // full product width
   localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int TW = N_WIDTH + 2;          // two's-complement working width, room for +/-360 deg
   localparam logic signed [TW-1:0] MAX_MAG = TW'((1 << MW) - 1);
   localparam logic signed [TW-1:0] HALF_TURN = TW'(180 << Q_WIDTH);
   localparam logic signed [TW-1:0] FULL_TURN = TW'(360 << Q_WIDTH);

   typedef enum logic [2:0] {S_IDLE, S_SAMP, S_MULX, S_MULY, S_MULT, S_ACC} state_t;

   logic               clk, rst_n, setb;
   logic [CW-1:0]      count;
   logic               tick;
   state_t             state, state_nxt;
   logic [N_WIDTH-1:0] snap_vx, snap_vy, snap_wz;
   logic [N_WIDTH-1:0] prod_x, prod_y, prod_t;
   logic [N_WIDTH-1:0] pos_x, pos_y, theta;
   logic               upd;
   logic [1:0]         ovf;
   logic [N_WIDTH-1:0] mul_in;
   logic [Q_WIDTH-1:0] mul_k;
   logic [PW-1:0]      mul_full;
   logic [MW-1:0]      mul_mag;
   logic [N_WIDTH-1:0] mul_out;
   logic signed [TW-1:0] sum_x, sum_y, sum_t, wrap_t;
   logic               sat_x, sat_y;
   logic [N_WIDTH-1:0] new_x, new_y, new_t;

   assign clk   = ODOM_INTEGRATOR_CLOCK_50;
   assign rst_n = ODOM_INTEGRATOR_RESET_InLow;
   assign setb  = ODOM_INTEGRATOR_SETBEGIN_InLow;
   assign tick  = (count == CW'(TICK_CYCLES - 1));

   function automatic logic signed [TW-1:0] sm2tc(input logic [N_WIDTH-1:0] v);
      logic signed [TW-1:0] m;
      m = TW'(v[MW-1:0]);
      return v[N_WIDTH-1] ? -m : m;
   endfunction

   // Zero comes out with a clear sign bit, so -0 never appears on the outputs.
   function automatic logic [N_WIDTH-1:0] tc2sm(input logic signed [TW-1:0] s);
      logic signed [TW-1:0] a;
      a = (s < 0) ? -s : s;
      return {s[TW-1], MW'(a)};
   endfunction

   // Integration tick counter; held at zero while disabled so the first tick is a full period out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              count <= '0;
      else if (!setb)                          count <= '0;
      else if (!ODOM_INTEGRATOR_ENABLE_InHigh) count <= '0;
      else if (tick)                           count <= '0;
      else                                     count <= count + CW'(1);
   end

   // Step sequencer state register; clear aborts any step in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     state <= S_IDLE;
      else if (!setb) state <= S_IDLE;
      else            state <= state_nxt;
   end

   // Step sequencer next state: one clock per stage.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (tick) state_nxt = S_SAMP;
         S_SAMP:  state_nxt = S_MULX;
         S_MULX:  state_nxt = S_MULY;
         S_MULY:  state_nxt = S_MULT;
         S_MULT:  state_nxt = S_ACC;
         S_ACC:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Shared multiplier: operand and constant selected by stage, magnitude truncated after the Q shift.
   always_comb begin
      mul_in = '0;
      mul_k  = '0;
      case (state)
         S_MULX: begin mul_in = snap_vx; mul_k = Q_WIDTH'(DT_K);    end
         S_MULY: begin mul_in = snap_vy; mul_k = Q_WIDTH'(DT_K);    end
         S_MULT: begin mul_in = snap_wz; mul_k = Q_WIDTH'(DTDEG_K); end
         default: ;
      endcase
      mul_full = PW'(mul_in[MW-1:0]) * PW'(mul_k);
      mul_mag  = MW'(mul_full >> Q_WIDTH);
      mul_out  = {mul_in[N_WIDTH-1] & (|mul_mag), mul_mag};
   end

   // Accumulation: saturating x/y, heading wrapped into (-180,180].
   always_comb begin
      sum_x = sm2tc(pos_x) + sm2tc(prod_x);
      sum_y = sm2tc(pos_y) + sm2tc(prod_y);
      sum_t = sm2tc(theta) + sm2tc(prod_t);
      sat_x = (sum_x > MAX_MAG) || (sum_x < -MAX_MAG);
      sat_y = (sum_y > MAX_MAG) || (sum_y < -MAX_MAG);
      new_x = sat_x ? {sum_x[TW-1], {MW{1'b1}}} : tc2sm(sum_x);
      new_y = sat_y ? {sum_y[TW-1], {MW{1'b1}}} : tc2sm(sum_y);
      wrap_t = sum_t;
      if (sum_t > HALF_TURN)        wrap_t = sum_t - FULL_TURN;
      else if (sum_t <= -HALF_TURN) wrap_t = sum_t + FULL_TURN;
      new_t = tc2sm(wrap_t);
   end

   // Datapath registers: snapshot, per-axis products, pose, update pulse and sticky overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap_vx <= '0; snap_vy <= '0; snap_wz <= '0;
         prod_x  <= '0; prod_y  <= '0; prod_t  <= '0;
         pos_x   <= X_INIT; pos_y <= Y_INIT; theta <= THETA_INIT;
         upd     <= 1'b0;
         ovf     <= 2'b00;
      end else if (!setb) begin
         pos_x <= X_INIT; pos_y <= Y_INIT; theta <= THETA_INIT;
         upd   <= 1'b0;
         ovf   <= 2'b00;
      end else begin
         upd <= (state == S_ACC);
         case (state)
            S_SAMP: begin
               snap_vx <= ODOM_INTEGRATOR_VX_InBus;
               snap_vy <= ODOM_INTEGRATOR_VY_InBus;
               snap_wz <= ODOM_INTEGRATOR_WZ_InBus;
            end
            S_MULX: prod_x <= mul_out;
            S_MULY: prod_y <= mul_out;
            S_MULT: prod_t <= mul_out;
            S_ACC: begin
               pos_x <= new_x;
               pos_y <= new_y;
               theta <= new_t;
               ovf   <= ovf | {sat_y, sat_x};
            end
            default: ;
         endcase
      end
   end

   assign ODOM_INTEGRATOR_POSX_OutBus    = pos_x;
   assign ODOM_INTEGRATOR_POSY_OutBus    = pos_y;
   assign ODOM_INTEGRATOR_THETA_OutBus   = theta;
   assign ODOM_INTEGRATOR_UPDATE_OutHigh = upd;
   assign ODOM_INTEGRATOR_OVF_OutBus     = ovf;

endmodule

// File: tb/tb_odom_integrator.sv
// tb/tb_odom_integrator.sv - directed-vector bench for odom_integrator
module tb_odom_integrator;

   localparam int N = 17;
   localparam logic [N-1:0] SGN = 17'h10000;

   logic         clk = 1'b0;
   logic         rst_n, setb, en;
   logic [N-1:0] vx, vy, wz;
   logic [N-1:0] posx, posy, theta;
   logic         upd;
   logic [1:0]   ovf;
   int           n_vec = 0;
   int           n_miss = 0;

   odom_integrator #(
      .N_WIDTH(17), .Q_WIDTH(8), .TICK_CYCLES(10), .DT_K(3), .DTDEG_K(147),
      .X_INIT('0), .Y_INIT('0), .THETA_INIT(17'd23040)
   ) dut (
      .ODOM_INTEGRATOR_CLOCK_50      (clk),
      .ODOM_INTEGRATOR_RESET_InLow   (rst_n),
      .ODOM_INTEGRATOR_SETBEGIN_InLow(setb),
      .ODOM_INTEGRATOR_ENABLE_InHigh (en),
      .ODOM_INTEGRATOR_VX_InBus      (vx),
      .ODOM_INTEGRATOR_VY_InBus      (vy),
      .ODOM_INTEGRATOR_WZ_InBus      (wz),
      .ODOM_INTEGRATOR_POSX_OutBus   (posx),
      .ODOM_INTEGRATOR_POSY_OutBus   (posy),
      .ODOM_INTEGRATOR_THETA_OutBus  (theta),
      .ODOM_INTEGRATOR_UPDATE_OutHigh(upd),
      .ODOM_INTEGRATOR_OVF_OutBus    (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_pose();
      @(negedge clk);
      en   = 1'b0;
      setb = 1'b0;
      @(negedge clk);
      setb = 1'b1;
   endtask

   // Enables the counter, counts n UPDATE pulses, then drops ENABLE before another tick can start.
   task automatic run_steps(input string tag, input int n);
      int seen = 0;
      int budget = n * 12 + 40;
      en = 1'b1;
      while (seen < n && budget > 0) begin
         @(negedge clk);
         budget--;
         if (upd) seen++;
      end
      en = 1'b0;
      check(tag, seen, n);
   endtask

   // Waits for one UPDATE pulse, leaving ENABLE as it is.
   task automatic wait_upd(input string tag);
      int budget = 40;
      bit got = 1'b0;
      while (!got && budget > 0) begin
         @(negedge clk);
         budget--;
         if (upd) got = 1'b1;
      end
      check(tag, got, 1);
   endtask

   task automatic count_quiet(input string tag, input int cycles);
      int seen = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (upd) seen++;
      end
      check(tag, seen, 0);
   endtask

   initial begin
      rst_n = 1'b0; setb = 1'b1; en = 1'b0;
      vx = '0; vy = '0; wz = '0;
      repeat (3) @(negedge clk);
      check("rst_posx", posx, 0);
      check("rst_posy", posy, 0);
      check("rst_theta", theta, 23040);
      check("rst_upd", upd, 0);
      check("rst_ovf", ovf, 0);
      rst_n = 1'b1;

      vx = 17'd256;
      run_steps("steps_vx1", 4);
      check("vx1_posx", posx, 12);
      check("vx1_posy", posy, 0);
      check("vx1_theta", theta, 23040);
      check("vx1_ovf", ovf, 0);
      @(negedge clk);
      check("upd_one_cycle", upd, 0);

      clear_pose();
      vx = '0; vy = SGN | 17'd256;
      run_steps("steps_vyneg", 2);
      check("vyneg_posy", posy, SGN | 17'd6);
      check("vyneg_posx", posx, 0);

      clear_pose();
      vy = '0; vx = 17'd128;
      run_steps("steps_trunc", 3);
      check("trunc_posx", posx, 3);

      clear_pose();
      vx = '0; wz = 17'd256;
      run_steps("steps_wz", 156);
      check("theta_pre_wrap", theta, 45972);
      run_steps("steps_wz_last", 1);
      check("theta_wrap", theta, SGN | 17'd46041);

      clear_pose();
      wz = '0; vx = 17'h0FFFF;
      run_steps("steps_sat_a", 85);
      check("sat_pre_posx", posx, 65195);
      check("sat_pre_ovf", ovf, 0);
      run_steps("steps_sat_b", 1);
      check("sat_posx", posx, 17'h0FFFF);
      check("sat_ovf", ovf, 2'b01);
      run_steps("steps_sat_c", 2);
      check("sat_hold_posx", posx, 17'h0FFFF);
      check("sat_hold_ovf", ovf, 2'b01);
      clear_pose();
      check("clr_posx", posx, 0);
      check("clr_ovf", ovf, 0);
      check("clr_theta", theta, 23040);

      vx = 17'd256;
      count_quiet("enable_low_quiet", 50);
      check("enable_low_posx", posx, 0);

      clear_pose();
      vx = 17'd256;
      en = 1'b1;
      wait_upd("snap_first");
      check("snap_first_posx", posx, 3);
      repeat (6) @(negedge clk);
      vx = 17'h0FFFF;
      wait_upd("snap_second");
      en = 1'b0;
      check("snap_posx", posx, 6);
      vx = 17'd256;

      clear_pose();
      en = 1'b1;
      wait_upd("acc_cal");
      check("acc_cal_posx", posx, 3);
      repeat (9) @(negedge clk);
      setb = 1'b0;
      en   = 1'b0;
      @(negedge clk);
      setb = 1'b1;
      check("acc_clr_upd", upd, 0);
      check("acc_clr_posx", posx, 0);
      count_quiet("acc_clr_quiet", 20);

      clear_pose();
      vy = 17'd256; wz = 17'd256;
      en = 1'b1;
      wait_upd("rst_cal");
      check("rst_cal_posy", posy, 3);
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("arst_posx", posx, 0);
      check("arst_posy", posy, 0);
      check("arst_theta", theta, 23040);
      @(negedge clk);
      en    = 1'b0;
      rst_n = 1'b1;
      count_quiet("arst_quiet", 20);
      check("arst_after_posx", posx, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
